// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray decode, popcount,
// pointer width derivation and sync-stage limits.
package fifo_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_CH          = 8;
  localparam int MAX_PW          = 32;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  // Operands are zero-extended to MAX_PW; leading zeros
  // decode to zeros, so the low PW bits stay correct.
  function automatic logic [MAX_PW-1:0] gray2bin(
    input logic [MAX_PW-1:0] g
  );
    logic [MAX_PW-1:0] b;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(
    input logic [MAX_PW-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PW; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_ch.sv
// Single-channel Gray pointer synchronizer chain.
// Ports: unsync_ptr in, sync_ptr/sync_ptr_bin, change pulse, sticky err.
module gray_ptr_sync_ch
  import fifo_pkg::*;
#(
  parameter int PW            = 5,
  parameter int NUM_OF_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [PW-1:0] unsync_ptr,
  input  logic          i_err_clr,
  input  logic          i_sync_valid,
  output logic [PW-1:0] sync_ptr,
  output logic [PW-1:0] sync_ptr_bin,
  output logic          o_ptr_changed,
  output logic          o_gray_err
);

  localparam int N = NUM_OF_STAGES;

  logic [PW-1:0] stage [N];
  logic          diff;
  logic          multi;

  always_comb begin
    diff  = (stage[N-2] != stage[N-1]);
    multi = popcount(MAX_PW'(stage[N-2] ^ stage[N-1])) > 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) begin
        stage[k] <= '0;
      end
      sync_ptr_bin  <= '0;
      o_ptr_changed <= 1'b0;
      o_gray_err    <= 1'b0;
    end else begin
      stage[0] <= unsync_ptr;
      for (int k = 1; k < N; k++) begin
        stage[k] <= stage[k-1];
      end
      // Decode one stage early so bin lines up with sync_ptr.
      sync_ptr_bin  <= PW'(gray2bin(MAX_PW'(stage[N-2])));
      o_ptr_changed <= i_sync_valid & diff;
      o_gray_err    <= (i_sync_valid & multi)
                     | (o_gray_err & ~i_err_clr);
    end
  end

  assign sync_ptr = stage[N-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel Gray pointer synchronizer with settle tracking.
// Ports: packed unsync_ptr in; sync_ptr, sync_ptr_bin, flags, o_sync_valid out.
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter  int ADDR_WIDTH    = 4,
  parameter  int NUM_OF_STAGES = 2,
  parameter  int NUM_CH        = 1,
  localparam int PW            = ptr_width(ADDR_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_CH*PW-1:0] unsync_ptr,
  input  logic                 i_err_clr,
  output logic [NUM_CH*PW-1:0] sync_ptr,
  output logic [NUM_CH*PW-1:0] sync_ptr_bin,
  output logic [NUM_CH-1:0]    o_ptr_changed,
  output logic [NUM_CH-1:0]    o_gray_err,
  output logic                 o_sync_valid
);

  localparam int CW = $clog2(NUM_OF_STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_OF_STAGES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_OF_STAGES - 1);

  if (NUM_OF_STAGES < MIN_SYNC_STAGES ||
      NUM_OF_STAGES > MAX_SYNC_STAGES ||
      NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_param
    $fatal(1, "gray_ptr_sync: illegal parameters");
  end

  logic [CW-1:0] cnt;

  // Valid rises on the edge that fills the last chain stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      o_sync_valid <= 1'b0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
      if (cnt == CNT_LAST) begin
        o_sync_valid <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gray_ptr_sync_ch #(
      .PW            (PW),
      .NUM_OF_STAGES (NUM_OF_STAGES)
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .unsync_ptr    (unsync_ptr[c*PW +: PW]),
      .i_err_clr     (i_err_clr),
      .i_sync_valid  (o_sync_valid),
      .sync_ptr      (sync_ptr[c*PW +: PW]),
      .sync_ptr_bin  (sync_ptr_bin[c*PW +: PW]),
      .o_ptr_changed (o_ptr_changed[c]),
      .o_gray_err    (o_gray_err[c])
    );
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync (3 stages, 2 channels).
// Expected values are hand-computed Gray/binary constants.
module tb_gray_ptr_sync;

  localparam int NS = 3;
  localparam int NC = 2;
  localparam int PW = 5;

  logic             clk;
  logic             rst_n;
  logic [NC*PW-1:0] unsync;
  logic             clr;
  logic [NC*PW-1:0] sync;
  logic [NC*PW-1:0] bin;
  logic [NC-1:0]    chg;
  logic [NC-1:0]    err;
  logic             valid;

  int n_vec = 0;
  int n_err = 0;

  gray_ptr_sync #(
    .ADDR_WIDTH    (4),
    .NUM_OF_STAGES (NS),
    .NUM_CH        (NC)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .unsync_ptr    (unsync),
    .i_err_clr     (clr),
    .sync_ptr      (sync),
    .sync_ptr_bin  (bin),
    .o_ptr_changed (chg),
    .o_gray_err    (err),
    .o_sync_valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Step ch0 by one legal Gray code and watch the pulse.
  task automatic step_ch0(input string tag,
                          input logic [4:0] g,
                          input logic [4:0] b);
    unsync[4:0] = g;
    repeat (NS) tick();
    chk({tag, "_chg"}, 32'(chg), 32'h1);
    chk({tag, "_sync"}, 32'(sync[4:0]), 32'(g));
    chk({tag, "_bin"}, 32'(bin[4:0]), 32'(b));
    chk({tag, "_err"}, 32'(err), 32'h0);
    tick();
    chk({tag, "_chg_end"}, 32'(chg), 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    unsync = '0;
    clr    = 1'b0;
    #12;
    chk("rst_sync", 32'(sync), 32'h0);
    chk("rst_bin", 32'(bin), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_vld", 32'(valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= NS; k++) begin
      tick();
      chk($sformatf("flush_vld_%0d", k),
          32'(valid), (k >= NS) ? 32'h1 : 32'h0);
      chk($sformatf("flush_chg_%0d", k),
          32'(chg), 32'h0);
    end

    // 00000 -> 00011 is also a 2-bit jump on ch0.
    unsync[4:0] = 5'b00011;
    for (int k = 1; k <= NS; k++) begin
      tick();
      chk($sformatf("lat_sync_%0d", k), 32'(sync[4:0]),
          (k == NS) ? 32'h03 : 32'h0);
      chk($sformatf("lat_bin_%0d", k), 32'(bin[4:0]),
          (k == NS) ? 32'h02 : 32'h0);
      chk($sformatf("lat_chg_%0d", k), 32'(chg),
          (k == NS) ? 32'h1 : 32'h0);
    end
    tick();
    chk("lat_chg_end", 32'(chg), 32'h0);
    chk("lat_err", 32'(err), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("lat_clr", 32'(err), 32'h0);

    unsync[4:0] = 5'b11000;
    repeat (NS + 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("wrap_pre_err", 32'(err), 32'h0);
    chk("wrap_pre_bin", 32'(bin[4:0]), 32'h10);
    step_ch0("wrap_a", 5'b10000, 5'b11111);
    step_ch0("wrap_b", 5'b00000, 5'b00000);

    unsync[9:5] = 5'b00011;
    repeat (NS) tick();
    chk("viol_err", 32'(err), 32'h2);
    chk("viol_chg", 32'(chg), 32'h2);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("viol_clr", 32'(err), 32'h0);

    unsync[9:5] = 5'b01100;
    repeat (NS - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("viol_clr_race", 32'(err), 32'h2);

    unsync[4:0] = 5'b00110;
    repeat (NS + 1) tick();
    chk("mid_pre_sync", 32'(sync[4:0]), 32'h06);
    chk("mid_pre_err", 32'(err), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_sync", 32'(sync), 32'h0);
    chk("mid_bin", 32'(bin), 32'h0);
    chk("mid_chg", 32'(chg), 32'h0);
    chk("mid_err", 32'(err), 32'h0);
    chk("mid_vld", 32'(valid), 32'h0);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= NS; k++) begin
      tick();
      chk($sformatf("refl_vld_%0d", k),
          32'(valid), (k >= NS) ? 32'h1 : 32'h0);
      chk($sformatf("refl_chg_%0d", k),
          32'(chg), 32'h0);
    end
    chk("refl_sync", 32'(sync), 32'h186);
    chk("refl_err", 32'(err), 32'h0);

    unsync[4:0] = 5'b01100;
    repeat (NS + 1) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("stab_chg_%0d", k), 32'(chg), 32'h0);
    end
    chk("stab_sync", 32'(sync[4:0]), 32'h0C);
    chk("stab_bin", 32'(bin[4:0]), 32'h08);
    chk("stab_vld", 32'(valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
